// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: drives the 8 user LEDs from two push-buttons.
// SW1 steps through four animation modes and SW2 freezes or unfreezes the
// animation. Each raw switch input goes through its own synchroniser and
// debouncer instance. A prescaled step timer sets the animation rate.

// Per-switch front end. The raw pin goes through a 2-FF synchroniser and a
// stability counter. The module produces a one-cycle press pulse on each
// debounced rising edge.
module led_pattern_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_pipe;
  logic          db;
  logic          db_d;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser; sync_pipe[1] is the metastability-safe copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], raw};
  end

  // The debounced value follows the synchronised value only after
  // DEBOUNCE_CYCLES consecutive mismatching cycles; any agreement restarts it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
    end else begin
      db_d <= db;
      if (sync_pipe[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync_pipe[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Rising edge of the debounced level only; releases are ignored
  assign press = db & ~db_d;
endmodule

module led_pattern_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_CYCLES     = 3000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       SW1,
  input  logic       SW2,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step
);
  localparam int NUM_SW = 2;
  localparam int SCW    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {
    M_ALT    = 2'd0,
    M_WALK   = 2'd1,
    M_BOUNCE = 2'd2,
    M_COUNT  = 2'd3
  } mode_t;

  // Bounce direction: 0 shifts toward LED8, 1 shifts toward LED1
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] press;

  mode_t          mode_q, mode_d;
  logic [7:0]     leds_q, leds_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           paused_q, paused_d;
  logic           step_q, step_d;
  logic           wrap;

  // Index 0 is the mode-advance button and index 1 is the pause button
  assign sw_raw = {SW2, SW1};

  genvar g;
  generate
    for (g = 0; g < NUM_SW; g++) begin : g_sw
      led_pattern_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rstn (rstn),
        .raw  (sw_raw[g]),
        .press(press[g])
      );
    end
  endgenerate

  // LED value loaded on entry to each mode
  function automatic logic [7:0] init_leds(input mode_t m);
    case (m)
      M_ALT:    init_leds = 8'h0F;
      M_WALK:   init_leds = 8'h01;
      M_BOUNCE: init_leds = 8'h01;
      default:  init_leds = 8'h00;
    endcase
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      M_ALT:    next_mode = M_WALK;
      M_WALK:   next_mode = M_BOUNCE;
      M_BOUNCE: next_mode = M_COUNT;
      default:  next_mode = M_ALT;
    endcase
  endfunction

  assign wrap = (cnt_q == SCW'(STEP_CYCLES - 1));

  // Register all state. Everything clears immediately when rstn goes low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= M_ALT;
      leds_q   <= 8'h0F;
      cnt_q    <= '0;
      dir_q    <= DIR_LEFT;
      paused_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      leds_q   <= leds_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      step_q   <= step_d;
    end
  end

  // Next-state logic. A mode change takes priority over a step on the same
  // edge. The pause toggle is independent of both
  always_comb begin
    mode_d   = mode_q;
    leds_d   = leds_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    paused_d = paused_q ^ press[1];
    step_d   = 1'b0;

    if (press[0]) begin
      mode_d = next_mode(mode_q);
      leds_d = init_leds(next_mode(mode_q));
      cnt_d  = '0;
      dir_d  = DIR_LEFT;
    end else if (!paused_q) begin
      if (wrap) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          M_ALT:  leds_d = ~leds_q;
          M_WALK: leds_d = {leds_q[6:0], leds_q[7]};
          M_BOUNCE: begin
            // Reverse at either end so each end LED is lit once per sweep
            if (dir_q == DIR_LEFT) begin
              if (leds_q == 8'h80) begin
                leds_d = 8'h40;
                dir_d  = DIR_RIGHT;
              end else begin
                leds_d = {leds_q[6:0], 1'b0};
              end
            end else begin
              if (leds_q == 8'h01) begin
                leds_d = 8'h02;
                dir_d  = DIR_LEFT;
              end else begin
                leds_d = {1'b0, leds_q[7:1]};
              end
            end
          end
          default: leds_d = leds_q + 8'd1;
        endcase
      end else begin
        cnt_d = cnt_q + SCW'(1);
      end
    end
  end

  assign leds   = leds_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign step   = step_q;
endmodule
